// File: rtl/vga_pkg.sv
// Shared constants for the VGA frame sequencer: default 640x480@60 timing and
// the geometry of the 128x96 one-bit-per-channel image BRAMs.
package vga_pkg;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int H_SYNC_START = 656;
    localparam int H_SYNC_END   = 751;
    localparam int V_SYNC_START = 490;
    localparam int V_SYNC_END   = 491;

    localparam int IMG_W  = 128;
    localparam int IMG_H  = 96;
    localparam int ADDR_W = 14;
    localparam int CNT_W  = 10;
endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-tick divider, horizontal/vertical counters and the blanking/sync decode
// of the current counter position.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick,
    output logic o_line_end,
    output logic o_frame_end,
    output logic o_frame_first,
    output logic o_h_act,
    output logic o_v_act,
    output logic o_v_last_act,
    output logic o_hsync_n,
    output logic o_vsync_n
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(V_VISIBLE - 1);
    localparam logic [CNT_W-1:0] HS_BEG   = CNT_W'(H_VISIBLE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_BEG   = CNT_W'(V_VISIBLE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_VISIBLE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             w_tick;
    logic             w_line_end;
    logic             w_v_last;

    assign w_tick     = (r_div == DIV_LAST);
    assign w_line_end = (r_h_cnt == H_LAST);
    assign w_v_last   = (r_v_cnt == V_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div   <= '0;
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) begin
                if (w_line_end) begin
                    r_h_cnt <= '0;
                    r_v_cnt <= w_v_last ? '0 : r_v_cnt + CNT_W'(1);
                end else begin
                    r_h_cnt <= r_h_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_tick        = w_tick;
    assign o_line_end    = w_line_end;
    assign o_frame_end   = w_line_end && w_v_last;
    assign o_frame_first = w_tick && (r_h_cnt == '0) && (r_v_cnt == '0);
    assign o_h_act       = (r_h_cnt < H_VIS);
    assign o_v_act       = (r_v_cnt < V_VIS);
    assign o_v_last_act  = (r_v_cnt == V_VIS_LAST);
    assign o_hsync_n     = !((r_h_cnt >= HS_BEG) && (r_h_cnt <= HS_END));
    assign o_vsync_n     = !((r_v_cnt >= VS_BEG) && (r_v_cnt <= VS_END));
endmodule

// File: rtl/vga_frame_sequencer.sv
// Scales the 128x96 RGB BRAM image 5x onto VGA: incremental address generation
// plus a one-tick realignment of colour and sync behind the BRAM read latency.
module vga_frame_sequencer
    import vga_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SCALE     = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              red_clr,
    input  logic              green_clr,
    input  logic              blue_clr,
    output logic [ADDR_W-1:0] pxl_addr,
    output logic [3:0]        vga_red,
    output logic [3:0]        vga_green,
    output logic [3:0]        vga_blue,
    output logic              vga_hsync,
    output logic              vga_vsync,
    output logic              frame_start
);
    localparam int COL_W = $clog2(IMG_W);
    localparam logic [2:0]        SUB_LAST   = 3'(SCALE - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(IMG_W);

    logic w_tick, w_line_end, w_frame_end, w_frame_first;
    logic w_h_act, w_v_act, w_v_last_act, w_hsync_n, w_vsync_n;

    vga_timing_gen #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VISIBLE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(V_VISIBLE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
    ) u_timing (
        .i_clk        (clk),
        .i_rst_n      (reset),
        .o_tick       (w_tick),
        .o_line_end   (w_line_end),
        .o_frame_end  (w_frame_end),
        .o_frame_first(w_frame_first),
        .o_h_act      (w_h_act),
        .o_v_act      (w_v_act),
        .o_v_last_act (w_v_last_act),
        .o_hsync_n    (w_hsync_n),
        .o_vsync_n    (w_vsync_n)
    );

    logic [2:0]        r_hsub, r_vsub;
    logic [COL_W-1:0]  r_col;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_pxl_addr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hsub     <= '0;
            r_vsub     <= '0;
            r_col      <= '0;
            r_row_base <= '0;
            r_pxl_addr <= '0;
        end else if (w_tick) begin
            r_pxl_addr <= r_row_base + {{(ADDR_W-COL_W){1'b0}}, r_col};
            if (w_line_end) begin
                r_hsub <= '0;
                r_col  <= '0;
                if (w_frame_end) begin
                    r_vsub     <= '0;
                    r_row_base <= '0;
                end else if (w_v_act) begin
                    if (r_vsub == SUB_LAST) begin
                        r_vsub     <= '0;
                        // Park on row 0 after the last image row so blanking addresses stay in range.
                        r_row_base <= w_v_last_act ? '0 : r_row_base + ROW_STRIDE;
                    end else begin
                        r_vsub <= r_vsub + 3'd1;
                    end
                end
            end else if (w_h_act) begin
                if (r_hsub == SUB_LAST) begin
                    r_hsub <= '0;
                    r_col  <= r_col + COL_W'(1);
                end else begin
                    r_hsub <= r_hsub + 3'd1;
                end
            end
        end
    end

    // First stage holds the decode for the address just issued; second stage
    // meets the BRAM data one tick later.
    logic       r_vis_d, r_hs_d, r_vs_d;
    logic [3:0] r_red, r_green, r_blue;
    logic       r_hsync, r_vsync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_vis_d <= 1'b0;
            r_hs_d  <= 1'b1;
            r_vs_d  <= 1'b1;
            r_red   <= 4'h0;
            r_green <= 4'h0;
            r_blue  <= 4'h0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_tick) begin
            r_vis_d <= w_h_act && w_v_act;
            r_hs_d  <= w_hsync_n;
            r_vs_d  <= w_vsync_n;
            r_red   <= r_vis_d ? {4{red_clr}}   : 4'h0;
            r_green <= r_vis_d ? {4{green_clr}} : 4'h0;
            r_blue  <= r_vis_d ? {4{blue_clr}}  : 4'h0;
            r_hsync <= r_hs_d;
            r_vsync <= r_vs_d;
        end
    end

    assign pxl_addr    = r_pxl_addr;
    assign vga_red     = r_red;
    assign vga_green   = r_green;
    assign vga_blue    = r_blue;
    assign vga_hsync   = r_hsync;
    assign vga_vsync   = r_vsync;
    assign frame_start = w_frame_first;
endmodule

// File: tb/tb_vga_frame_sequencer.sv
// Randomised-image bench for vga_frame_sequencer: a tick-indexed pixel model predicts
// every output each cycle; a few hand-derived edge timings pin the model.
module tb_vga_frame_sequencer;
    localparam int CLK_DIV = 4;
    localparam int H_VIS = 640, H_FP = 16, H_SYNC = 96, H_BP = 48;
    localparam int V_VIS = 10, V_FP = 1, V_SYNC = 2, V_BP = 1;
    localparam int SCALE = 5, IMG_W = 128, IMG_PIX = 128 * 96;
    localparam int HT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int VT = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int FRAME = HT * VT;
    localparam int MAX_ADDR = (V_VIS / SCALE) * IMG_W - 1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        red_clr = 1'b0, green_clr = 1'b0, blue_clr = 1'b0;
    logic [13:0] pxl_addr;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic        vga_hsync, vga_vsync, frame_start;

    vga_frame_sequencer #(
        .CLK_DIV(CLK_DIV), .H_VISIBLE(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_VISIBLE(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP), .SCALE(SCALE)
    ) dut (
        .clk(clk), .reset(reset),
        .red_clr(red_clr), .green_clr(green_clr), .blue_clr(blue_clr),
        .pxl_addr(pxl_addr), .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    int e_cnt = 0;
    int mode = 0;  // 0 random image, 1 red only, 2 all ones
    bit phase0 = 1'b1;
    int fs_e = -1;
    int hs_fall0 = -1, hs_fall1 = -1, hs_rise = -1, vs_fall = -1, vs_rise = -1;
    bit hs_prev = 1'b1, vs_prev = 1'b1;
    bit img [3][IMG_PIX];

    // Clock edges since reset release; edge 4*(k+1) is pixel tick k.
    always @(posedge clk or negedge reset)
        if (!reset) e_cnt <= 0;
        else        e_cnt <= e_cnt + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_le(input string nm, input logic [31:0] act, input int lim);
        n_tests++;
        if ($isunknown(act) || act > lim) begin
            n_fail++;
            $display("FAIL %s: got %0d expected <= %0d at t=%0t", nm, act, lim, $time);
        end
    endtask

    function automatic bit vis(input int h, input int v);
        return (h < H_VIS) && (v < V_VIS);
    endfunction

    function automatic int addr_of(input int h, input int v);
        return (v / SCALE) * IMG_W + h / SCALE;
    endfunction

    function automatic bit pix(input int c, input int a);
        if (a < 0 || a >= IMG_PIX) return 1'b0;
        case (mode)
            0:       return img[c][a];
            1:       return (c == 0);
            default: return 1'b1;
        endcase
    endfunction

    // BRAM model: data for the address seen at an edge is stable shortly after it.
    initial forever begin
        @(posedge clk);
        #1;
        red_clr   = pix(0, int'(pxl_addr));
        green_clr = pix(1, int'(pxl_addr));
        blue_clr  = pix(2, int'(pxl_addr));
    end

    initial begin
        int n, p, h, v, a;
        logic [11:0] exp_rgb;
        logic [1:0]  exp_sync;
        bit          exp_fs;
        forever begin
            @(negedge clk);
            if (!reset) begin
                chk("rst_addr", 32'(pxl_addr), 0);
                chk("rst_rgb", 32'({vga_red, vga_green, vga_blue}), 0);
                chk("rst_sync", 32'({vga_hsync, vga_vsync}), 3);
                chk("rst_frame_start", 32'(frame_start), 0);
            end else begin
                n = e_cnt / CLK_DIV;
                if (n == 0) chk("addr_pre_tick", 32'(pxl_addr), 0);
                else begin
                    p = (n - 1) % FRAME; h = p % HT; v = p / HT;
                    if (vis(h, v)) chk("addr", 32'(pxl_addr), addr_of(h, v));
                    else           chk_le("addr_blank", 32'(pxl_addr), MAX_ADDR);
                end
                exp_rgb = '0;
                exp_sync = 2'b11;
                if (n >= 2) begin
                    p = (n - 2) % FRAME; h = p % HT; v = p / HT;
                    if (vis(h, v)) begin
                        a = addr_of(h, v);
                        exp_rgb = {{4{pix(0, a)}}, {4{pix(1, a)}}, {4{pix(2, a)}}};
                    end
                    exp_sync[1] = !(h >= H_VIS + H_FP && h < H_VIS + H_FP + H_SYNC);
                    exp_sync[0] = !(v >= V_VIS + V_FP && v < V_VIS + V_FP + V_SYNC);
                end
                chk("rgb", 32'({vga_red, vga_green, vga_blue}), 32'(exp_rgb));
                chk("sync", 32'({vga_hsync, vga_vsync}), 32'(exp_sync));
                exp_fs = 1'b0;
                if ((e_cnt + 1) % CLK_DIV == 0) exp_fs = (((e_cnt + 1) / CLK_DIV - 1) % FRAME) == 0;
                chk("frame_start", 32'(frame_start), 32'(exp_fs));

                if (frame_start === 1'b1 && fs_e < 0) fs_e = e_cnt;
                if (phase0) begin
                    if (e_cnt == 24)    chk("addr_h5_lit", 32'(pxl_addr), 1);
                    if (e_cnt == 16004) chk("addr_line5_lit", 32'(pxl_addr), 128);
                    if (e_cnt == 31360) chk("addr_last_vis_lit", 32'(pxl_addr), 255);
                    if (!vga_hsync && hs_prev) begin
                        if (hs_fall0 < 0) hs_fall0 = e_cnt;
                        else if (hs_fall1 < 0) hs_fall1 = e_cnt;
                    end
                    if (vga_hsync && !hs_prev && hs_rise < 0) hs_rise = e_cnt;
                    if (!vga_vsync && vs_prev && vs_fall < 0) vs_fall = e_cnt;
                    if (vga_vsync && !vs_prev && vs_rise < 0) vs_rise = e_cnt;
                end
                hs_prev = vga_hsync;
                vs_prev = vga_vsync;
            end
        end
    end

    task automatic wait_tick(input int k);
        while (e_cnt < (k + 1) * CLK_DIV && n_fail <= 200) @(posedge clk);
    endtask

    initial begin
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < IMG_PIX; i++) img[c][i] = 1'($urandom_range(0, 1));
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;

        wait_tick(10 * HT + 10);
        #1 mode = 2;
        wait_tick(13 * HT + 10);
        #1 mode = 1;
        chk("fs_first_edge", fs_e, 3);
        chk("hs_fall_offset", hs_fall0 - 4, 2628);
        chk("hs_low_width", hs_rise - hs_fall0, 384);
        chk("hs_period", hs_fall1 - hs_fall0, 3200);
        chk("vs_low_width", vs_rise - vs_fall, 6400);

        // Mid-frame reset with counters at h=300, v=2.
        wait_tick(FRAME + 2 * HT + 299);
        #1 reset = 1'b0;
        phase0 = 1'b0;
        #1;
        chk("midrst_addr", 32'(pxl_addr), 0);
        chk("midrst_rgb", 32'({vga_red, vga_green, vga_blue}), 0);
        chk("midrst_sync", 32'({vga_hsync, vga_vsync}), 3);
        chk("midrst_frame_start", 32'(frame_start), 0);
        repeat (2) @(posedge clk);
        #1 fs_e = -1;
        reset = 1'b1;
        wait_tick(2 * HT + 10);
        chk("fs_after_reset_edge", fs_e, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
